// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular transmit FIFO; parity, stop bits and depth set by parameters.
// Frames run back-to-back whenever the FIFO holds a word at the end of the stop period.
module uart_tx_fifo #(
  parameter int CLKDIV   = 833,
  parameter int DIVBITS  = 10,
  parameter int DATABITS = 8,
  parameter int PARITY   = 0,
  parameter int STOPBITS = 1,
  parameter int FIFOAW   = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [DATABITS-1:0] wdata,
  input  logic                wr,
  input  logic                ovf_clr,
  output logic                full,
  output logic                empty,
  output logic [FIFOAW:0]     level,
  output logic                busy,
  output logic                ovf,
  output logic                tx
);

  localparam int                 DEPTH     = 1 << FIFOAW;
  localparam logic [DIVBITS-1:0] CNT_LAST  = DIVBITS'(CLKDIV - 1);
  localparam logic [3:0]         DATA_LAST = 4'(DATABITS - 1);
  localparam logic [3:0]         STOP_LAST = 4'(STOPBITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t              state;
  logic [DATABITS-1:0] mem [DEPTH];
  logic [FIFOAW-1:0]   wptr;
  logic [FIFOAW-1:0]   rptr;
  logic [DIVBITS-1:0]  cnt;
  logic [3:0]          bitcnt;
  logic [DATABITS-1:0] shreg;
  logic                par_bit;
  logic [DATABITS-1:0] head;
  logic                head_par;
  logic                bit_end;
  logic                push;
  logic                pop;

  assign full     = (level == (FIFOAW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign head     = mem[rptr];
  assign head_par = (^head) ^ (PARITY == 2);
  assign bit_end  = (cnt == CNT_LAST);

  // Pop happens from IDLE, or on the last clock of the stop period for a zero-gap restart.
  always_comb begin
    push = wr && !full;
    pop  = 1'b0;
    if (!empty) begin
      if (state == IDLE)
        pop = 1'b1;
      else if (state == STOP && bit_end && bitcnt == STOP_LAST)
        pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && n_rst)
      mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
      if (wr && full)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  // tx is registered from the current state, so the line trails the FSM by one clock.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      busy <= (state != IDLE) || !empty;
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shreg[0];
        PAR:     tx <= par_bit;
        default: tx <= 1'b1;
      endcase
      if (state != IDLE)
        cnt <= bit_end ? '0 : cnt + 1'b1;
      if (pop) begin
        shreg   <= head;
        par_bit <= head_par;
      end
      case (state)
        IDLE:  if (pop) state <= START;
        START: if (bit_end) state <= DATA;
        DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bitcnt == DATA_LAST) begin
              bitcnt <= '0;
              state  <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        PAR:   if (bit_end) state <= STOP;
        STOP: begin
          if (bit_end) begin
            if (bitcnt == STOP_LAST) begin
              bitcnt <= '0;
              state  <= pop ? START : IDLE;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with an internal transmit FIFO.
- Data width, parity mode, stop-bit count and FIFO depth are configurable.
- Supports back-to-back frames with no idle gap and sticky overflow detection.
- Sits between a CPU or debug bus write port and the board TX pin; the producer pushes words without waiting for each frame to finish.

Parameters:
- CLKDIV, 833, clocks per bit (9600 bps at 8 MHz); legal range 2..2^DIVBITS-1.
- DIVBITS, 10, width of the bit-period counter.
- DATABITS, 8, data bits per frame; legal 5..9.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOPBITS, 1, number of stop bits; legal 1 or 2.
- FIFOAW, 4, FIFO address width; depth = 2^FIFOAW words.

Ports:
- clk  input  1  clock, all logic on rising edge.
- n_rst  input  1  synchronous reset, active-low.
- wdata  input  DATABITS  word to enqueue.
- wr  input  1  push strobe, one word per cycle while high.
- ovf_clr  input  1  clears the ovf flag.
- full  output  1  FIFO holds 2^FIFOAW words.
- empty  output  1  FIFO holds 0 words.
- level  output  FIFOAW+1  current FIFO occupancy.
- busy  output  1  a frame is on the line, or the FIFO is non-empty.
- ovf  output  1  sticky: a push was attempted while full.
- tx  output  1  serial line, idles high.

Behaviour:
- Reset: n_rst is sampled low at a clk edge. After that edge: tx=1, busy=0, ovf=0, level=0, empty=1, full=0, FIFO pointers at 0, FSM in IDLE, bit counters at 0. Reset mid-frame aborts the frame immediately, with tx high from the next edge, and discards FIFO contents.
- FIFO: circular buffer of 2^FIFOAW x DATABITS with registered write and read pointers (FIFOAW bits, natural wrap) and a level counter.
  - full = (level == 2^FIFOAW).
  - empty = (level == 0).
  - A push is accepted iff wr && !full, evaluated on the registered full.
  - A push while full is dropped, the FIFO is unchanged, and ovf is set to 1 on that edge.
  - Push and pop on the same edge: both take effect and level is unchanged. This applies only when not full; a pop on a full FIFO does not make room for a same-cycle push.
- ovf: ovf_clr=1 clears it. If ovf_clr and a dropped push coincide, set wins.
- Bit timing: each line bit lasts exactly CLKDIV clocks. The counter runs 0..CLKDIV-1 and the bit advances when the counter reaches CLKDIV-1.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx=1. If !empty, pop the FIFO head into the shift register and go to START on the same edge.
  - START: tx=0 for CLKDIV clocks, then DATA.
  - DATA: tx = shift register LSB. Shift right once per bit. Go to PAR after DATABITS bits, or to STOP if PARITY==0.
  - PAR: tx = XOR of the data bits for even parity, XNOR for odd. Parity is computed from the popped word at pop time, not from the shifted register.
  - STOP: tx=1 for STOPBITS x CLKDIV clocks.
    - At the final clock of the stop period, if !empty, pop the next word and go straight to START. The next start bit begins on the very next clock with zero idle gap.
    - Otherwise go to IDLE.
- Frame length: (1 + DATABITS + (PARITY!=0) + STOPBITS) x CLKDIV clocks.
- Latency: wr accepted at edge E0 into an empty FIFO with the FSM in IDLE.
  - Word becomes visible (empty=0) after E0.
  - Popped at E1; tx=0 from E2.
  - Start-bit to next start-bit spacing for back-to-back words equals the frame length exactly.
- busy = (FSM != IDLE) || !empty, registered. It drops one clock after the final stop bit ends with the FIFO empty.
- tx is driven from a register, with no combinational path from any input to tx.
- Illegal parameter values (PARITY>2, STOPBITS outside 1..2, CLKDIV<2) are unsupported. The implementation adds no runtime checks.

Test Plan:
- Reset then idle (CLKDIV=4, 8N1): hold n_rst low 3 clocks, release -> tx=1, busy=0, empty=1, level=0, ovf=0 for 100 clocks.
- Single byte 8N1, CLKDIV=4: wr 0xA5 at edge E0 -> tx low from E2 for 4 clocks, then bits 1,0,1,0,0,1,0,1 each 4 clocks, stop high 4 clocks; busy falls 1 clock after stop ends; total frame 40 clocks.
- Back-to-back with parity (PARITY=1, STOPBITS=2, CLKDIV=4): push 0x03,0x80 on consecutive clocks -> two frames of 48 clocks each.
  - Frame 1 parity bit 0, frame 2 parity bit 1.
  - The 2nd start bit begins exactly 48 clocks after the 1st, with no idle cycle.
  - Odd-parity rerun gives 1 then 0.
- Fill and overflow (FIFOAW=2): with tx stalled by a first frame in progress, push 6 words -> level rises to 4, full=1, ovf=1 after the first rejected push. All 5 accepted words (1 in flight plus 4 queued) are transmitted in order; the 6th is absent. ovf_clr clears ovf. Pointer wrap is checked by pushing 10 more words in groups of 3.
- Simultaneous push/pop: push exactly on the STOP-final edge while level=1 -> level stays 1, the popped word starts immediately, and the new word is transmitted next.
- Reset mid-frame: assert n_rst low during data bit 3 with level=2 -> tx=1 next clock, level=0, busy=0. The next pushed word 0x5A is transmitted cleanly with correct timing.
